// File: rtl/operand_fetch.sv
//------------------------------------------------------------------------------
// Module   : operand_fetch
// Brief    : Decode-to-execute operand fetch with registered-read RF and forwarding
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module operand_fetch #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic                 wb_wen,
  input  logic [4:0]           wb_waddr,
  input  logic [31:0]          wb_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_op1,
  output logic [31:0]          out_op2,
  output logic [4:0]           out_rd,
  output logic [PAYLOAD_W-1:0] out_payload
);

  localparam logic [4:0] C_X0 = 5'd0;

  // R stage
  logic                 r_valid;
  logic [4:0]           r_rs1;
  logic [4:0]           r_rs2;
  logic [4:0]           r_rd;
  logic [PAYLOAD_W-1:0] r_payload;

  // last-write register
  logic                 r_lw_valid;
  logic [4:0]           r_lw_addr;
  logic [31:0]          r_lw_data;

  // O stage
  logic                 r_out_valid;
  logic [4:0]           r_o_rs1;
  logic [4:0]           r_o_rs2;
  logic [31:0]          r_out_op1;
  logic [31:0]          r_out_op2;
  logic [4:0]           r_out_rd;
  logic [PAYLOAD_W-1:0] r_out_payload;

  logic                 w_accept;
  logic                 w_advance;
  logic                 w_in_ready;
  logic [31:0]          w_op1;
  logic [31:0]          w_op2;

  function automatic logic [31:0] resolve(
    input logic [4:0]  idx,
    input logic [31:0] rdata,
    input logic        wen,
    input logic [4:0]  waddr,
    input logic [31:0] wdata,
    input logic        lwv,
    input logic [4:0]  lwa,
    input logic [31:0] lwd
  );
    logic [31:0] v;
    if (idx == C_X0)                 v = 32'd0;
    else if (wen && (waddr == idx))  v = wdata;
    else if (lwv && (lwa == idx))    v = lwd;
    else                             v = rdata;
    return v;
  endfunction

  assign w_advance  = r_valid & (~r_out_valid | out_ready);
  assign w_in_ready = ~flush & (~r_valid | w_advance);
  assign w_accept   = in_valid & w_in_ready;

  // Stalled R keeps re-reading its own indices so rf_rdata never goes stale.
  assign rf_rs1 = w_accept ? in_rs1 : r_rs1;
  assign rf_rs2 = w_accept ? in_rs2 : r_rs2;

  assign w_op1 = resolve(r_rs1, rf_rdata1, wb_wen, wb_waddr, wb_wdata,
                         r_lw_valid, r_lw_addr, r_lw_data);
  assign w_op2 = resolve(r_rs2, rf_rdata2, wb_wen, wb_waddr, wb_wdata,
                         r_lw_valid, r_lw_addr, r_lw_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lw_valid <= 1'b0;
      r_lw_addr  <= 5'd0;
      r_lw_data  <= 32'd0;
    end else begin
      r_lw_valid <= wb_wen;
      r_lw_addr  <= wb_waddr;
      r_lw_data  <= wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_rd      <= 5'd0;
      r_payload <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_rs1     <= in_rs1;
      r_rs2     <= in_rs2;
      r_rd      <= in_rd;
      r_payload <= in_payload;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_o_rs1       <= 5'd0;
      r_o_rs2       <= 5'd0;
      r_out_op1     <= 32'd0;
      r_out_op2     <= 32'd0;
      r_out_rd      <= 5'd0;
      r_out_payload <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_out_valid   <= 1'b1;
      r_o_rs1       <= r_rs1;
      r_o_rs2       <= r_rs2;
      r_out_op1     <= w_op1;
      r_out_op2     <= w_op2;
      r_out_rd      <= r_rd;
      r_out_payload <= r_payload;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else if (r_out_valid) begin
      // Held operands track writebacks so they are current when execute takes them.
      if (wb_wen && (wb_waddr != C_X0) && (wb_waddr == r_o_rs1)) r_out_op1 <= wb_wdata;
      if (wb_wen && (wb_waddr != C_X0) && (wb_waddr == r_o_rs2)) r_out_op2 <= wb_wdata;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_op1     = r_out_op1;
  assign out_op2     = r_out_op2;
  assign out_rd      = r_out_rd;
  assign out_payload = r_out_payload;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
//------------------------------------------------------------------------------
// Module   : tb_operand_fetch
// Brief    : Directed self-checking bench for operand_fetch with a registered-read RF model
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_fetch;

  localparam int PAYLOAD_W = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [4:0]           in_rd;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [4:0]           rf_rs1;
  logic [4:0]           rf_rs2;
  logic [31:0]          rf_rdata1;
  logic [31:0]          rf_rdata2;
  logic                 wb_wen;
  logic [4:0]           wb_waddr;
  logic [31:0]          wb_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_op1;
  logic [31:0]          out_op2;
  logic [4:0]           out_rd;
  logic [PAYLOAD_W-1:0] out_payload;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [32];

  operand_fetch #(.PAYLOAD_W(PAYLOAD_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_payload  (in_payload),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .wb_wen      (wb_wen),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_rd      (out_rd),
    .out_payload (out_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: 1-cycle registered read, read-before-write, preloaded in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= {16'hA000, 16'(i)};
      mem[0] <= 32'd0;
      mem[5] <= 32'h11;
      mem[6] <= 32'h22;
      rf_rdata1 <= 32'd0;
      rf_rdata2 <= 32'd0;
    end else begin
      rf_rdata1 <= mem[rf_rs1];
      rf_rdata2 <= mem[rf_rs2];
      if (wb_wen) mem[wb_waddr] <= wb_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [31:0] pl);
    in_valid   = v;
    in_rs1     = s1;
    in_rs2     = s2;
    in_rd      = d;
    in_payload = pl;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wen   = en;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0);
    wb(0, 0, 0);

    // reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_op1", out_op1, 0);
    check("rst_op2", out_op2, 0);
    check("rst_rd", out_rd, 0);
    check("rst_payload", out_payload, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    tick();

    // basic fetch, latency 2
    out_ready = 1'b1;
    set_in(1, 5, 6, 7, 32'hA5);
    @(negedge clk); check("t1_in_ready", in_ready, 1); tick();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); check("t1_not_yet", out_valid, 0); tick();
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_op1", out_op1, 32'h11);
    check("t1_op2", out_op2, 32'h22);
    check("t1_rd", out_rd, 7);
    check("t1_payload", out_payload, 32'hA5);
    tick();
    @(negedge clk); check("t1_drained", out_valid, 0); tick();

    // writeback in accept cycle -> last-write path
    set_in(1, 5, 6, 8, 1);
    wb(1, 5, 32'hDEAD);
    @(negedge clk); tick();
    set_in(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    @(negedge clk); tick();
    @(negedge clk);
    check("t2a_valid", out_valid, 1);
    check("t2a_op1_lw", out_op1, 32'hDEAD);
    check("t2a_op2", out_op2, 32'h22);
    tick();

    // writeback in R cycle -> current-writeback path
    set_in(1, 5, 6, 9, 2);
    @(negedge clk); tick();
    set_in(0, 0, 0, 0, 0);
    wb(1, 5, 32'hCAFE);
    @(negedge clk); tick();
    wb(0, 0, 0);
    @(negedge clk);
    check("t2b_valid", out_valid, 1);
    check("t2b_op1_wb", out_op1, 32'hCAFE);
    tick();

    // x0 always reads zero
    set_in(1, 0, 6, 10, 3);
    wb(1, 0, 32'hFFFF_FFFF);
    @(negedge clk); tick();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); tick();
    wb(0, 0, 0);
    @(negedge clk);
    check("t3_op1_x0", out_op1, 0);
    check("t3_op2", out_op2, 32'h22);
    tick();

    // output stall with O snoop and R re-read
    out_ready = 1'b0;
    set_in(1, 5, 6, 1, 32'h11);
    @(negedge clk); tick();
    set_in(1, 6, 5, 2, 32'h12);
    @(negedge clk); check("t4_ready_fill", in_ready, 1); tick();
    set_in(0, 0, 0, 0, 0);
    wb(1, 6, 32'h99);
    @(negedge clk);
    check("t4_full_ready", in_ready, 0);
    check("t4_valid", out_valid, 1);
    check("t4_op2_before", out_op2, 32'h22);
    tick();
    wb(0, 0, 0);
    @(negedge clk);
    check("t4_op2_snoop", out_op2, 32'h99);
    check("t4_hold_valid", out_valid, 1);
    tick();
    @(negedge clk); check("t4_ready_stall2", in_ready, 0); tick();
    @(negedge clk); check("t4_ready_stall3", in_ready, 0); tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_ready_release", in_ready, 1);
    check("t4_a_op1", out_op1, 32'hCAFE);
    check("t4_a_op2", out_op2, 32'h99);
    check("t4_a_rd", out_rd, 1);
    tick();
    @(negedge clk);
    check("t4_b_valid", out_valid, 1);
    check("t4_b_op1_reread", out_op1, 32'h99);
    check("t4_b_op2", out_op2, 32'hCAFE);
    check("t4_b_rd", out_rd, 2);
    tick();
    @(negedge clk); check("t4_drained", out_valid, 0); tick();

    // 8 back-to-back instructions
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) set_in(1, 5'(8 + c), 5'(16 + c), 5'(c), 32'(c));
      else       set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      if (c < 8) check($sformatf("t5_ready_%0d", c), in_ready, 1);
      if (c >= 2) begin
        check($sformatf("t5_valid_%0d", c - 2), out_valid, 1);
        check($sformatf("t5_op1_%0d", c - 2), out_op1, {16'hA000, 16'(8 + c - 2)});
        check($sformatf("t5_op2_%0d", c - 2), out_op2, {16'hA000, 16'(16 + c - 2)});
        check($sformatf("t5_rd_%0d", c - 2), out_rd, 32'(c - 2));
        check($sformatf("t5_pl_%0d", c - 2), out_payload, 32'(c - 2));
      end
      tick();
    end
    @(negedge clk); check("t5_drained", out_valid, 0); tick();

    // flush with R and O full
    out_ready = 1'b0;
    set_in(1, 5, 6, 3, 32'h21);
    @(negedge clk); tick();
    set_in(1, 6, 5, 4, 32'h22);
    @(negedge clk); tick();
    set_in(1, 7, 7, 5, 32'h23);
    flush = 1'b1;
    @(negedge clk);
    check("t6_flush_ready", in_ready, 0);
    check("t6_pre_valid", out_valid, 1);
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_flushed_valid", out_valid, 0);
    check("t6_accept_ready", in_ready, 1);
    tick();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); check("t6_r_only", out_valid, 0); tick();
    @(negedge clk);
    check("t6_c_valid", out_valid, 1);
    check("t6_c_rd", out_rd, 5);
    check("t6_c_op1", out_op1, 32'hA000_0007);
    check("t6_c_payload", out_payload, 32'h23);
    tick();
    @(negedge clk); check("t6_single", out_valid, 0); tick();

    // asynchronous reset mid-operation
    set_in(1, 8, 9, 6, 32'h31);
    @(negedge clk); tick();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); tick();
    #1;
    check("t7_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_valid_async", out_valid, 0);
    check("t7_op1_async", out_op1, 0);
    check("t7_rd_async", out_rd, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_after_valid", out_valid, 0);
    check("t7_after_ready", in_ready, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
